// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry, default reset image and
// the hardwired-zero helper used by both the storage array and the scoreboard.
package regfile_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);
    localparam int MAX_NRD   = 8;

    typedef logic [DEF_AW-1:0]    reg_addr_t;
    typedef logic [DEF_WIDTH-1:0] reg_data_t;

    // Register i lives at bits [WIDTH*i +: WIDTH]; reg 1 and reg 2 carry the legacy trim values.
    localparam logic [DEF_DEPTH*DEF_WIDTH-1:0] DEF_RESET_VAL =
        {24'h000000, 24'h126728, 24'h884121, 24'h000000};

    // True when the address selects the hardwired zero register.
    function automatic logic is_zero_reg(input int zero_en, input int addr);
        return (zero_en != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: a register is marked busy when an instruction
// targeting it issues and released when its write-back lands. A reserve in the
// same cycle as a write-back to the same register wins, because it names a new
// producer that is still in flight.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    port_busy,
    output logic              any_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_next;

    // Release on write-back first, then apply the reserve so it takes priority.
    always_comb begin
        busy_next = busy_q;
        if (we) begin
            busy_next[waddr] = 1'b0;
        end
        if (rsv_en && !is_zero_reg(ZERO_REG, int'(rsv_addr))) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_lookup
        assign port_busy[p] = busy_q[raddr[AW*p +: AW]];
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write-to-read bypass, optional
// hardwired zero register, optional registered read stage and a busy
// scoreboard for datapath stall detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = 2,
    parameter int RD_REG   = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VAL = DEF_RESET_VAL,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 any_busy
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [NRD-1:0]       sb_busy;
    logic [NRD*WIDTH-1:0] rd_c;
    logic [NRD-1:0]       rb_c;

    // Storage array: reset image load, then single write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= is_zero_reg(ZERO_REG, i) ? '0 : RESET_VAL[WIDTH*i +: WIDTH];
            end
        end else if (we && !is_zero_reg(ZERO_REG, int'(waddr))) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .raddr     (raddr),
        .port_busy (sb_busy),
        .any_busy  (any_busy)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0]    ra;
        logic             hit;
        logic [WIDTH-1:0] d;
        logic             b;

        assign ra  = raddr[AW*p +: AW];
        assign hit = (BYPASS != 0) && we && (waddr == ra);

        // Read mux: zero register first, then bypass, then stored state.
        // A forwarded write has retired its producer unless a new one reserves in the same cycle.
        always_comb begin
            d = mem[ra];
            b = sb_busy[p];
            if (is_zero_reg(ZERO_REG, int'(ra))) begin
                d = '0;
                b = 1'b0;
            end else if (hit) begin
                d = wdata;
                b = rsv_en && (rsv_addr == ra);
            end
        end

        assign rd_c[WIDTH*p +: WIDTH] = d;
        assign rb_c[p]                = b;
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [NRD*WIDTH-1:0] rdata_q;
        logic [NRD-1:0]       rbusy_q;

        // Registered read stage: captures cycle-N read (bypass included) for use in cycle N+1.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata_q <= '0;
                rbusy_q <= '0;
            end else begin
                rdata_q <= rd_c;
                rbusy_q <= rb_c;
            end
        end

        assign rdata = rdata_q;
        assign rbusy = rbusy_q;
    end else begin : g_rd_comb
        assign rdata = rd_c;
        assign rbusy = rb_c;
    end

    a_ctrl_known: assert property (@(posedge clk) disable iff (!reset) !$isunknown({we, rsv_en}));

endmodule
